gen_fip_sign_mac: RTL and testbench
===================================

# gen_fip_sign_mac

Sequential signed fixed-point multiply-accumulate stage that consumes pairs of operands in the same Q(INT.FRACT) format used by the gen_fip_sign_* arithmetic units. It computes a saturating dot product over a vector of operand pairs delivered one per start pulse, with the last pair flagged. It returns the sum with a single-cycle done pulse. It sits downstream of the operand producers and upstream of the adder, distance and comparator units, which consume its o_res.

## Interface
- IN_INT_W, default 1: integer bits of each input, including the sign bit.
- IN_FRACT_W, default 5: fractional bits of each input.
- ACC_INT_W, default 4: integer bits of the accumulator and result, including the sign bit. Must be ≥ 2*IN_INT_W.
- CNT_W, default 8: width of the element counter.
- Derived widths:
  - IN_W = IN_INT_W+IN_FRACT_W.
  - PROD_W = 2*IN_W, with 2*IN_FRACT_W fractional bits.
  - ACC_W = ACC_INT_W+2*IN_FRACT_W.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset; clears all state.
- sw_rst  in  1  synchronous soft reset; same clearing effect as rst, takes priority over all other inputs.
- i_start_pls  in  1  one-cycle pulse; i_num1, i_num2 and i_last are valid in this cycle. May be high every cycle.
- i_num1  in  IN_W  signed fixed-point operand.
- i_num2  in  IN_W  signed fixed-point operand.
- i_last  in  1  marks the pair as the last element of the vector; sampled only with i_start_pls.
- o_done_pls  out  1  one-cycle pulse; o_res, o_ovf and o_cnt are valid and held until the next o_done_pls.
- o_res  out  ACC_W  saturated dot product, ACC_INT_W integer bits and 2*IN_FRACT_W fractional bits.
- o_ovf  out  1  at least one saturation event occurred in the reported vector.
- o_cnt  out  CNT_W  number of elements in the reported vector; saturates at 2^CNT_W-1.

## Operation
- Stage 1 (multiply): on i_start_pls, register:
  - the exact signed product num1*num2 (PROD_W bits, no rounding);
  - p_vld=1 and p_last=i_last.
- p_vld is 0 in every cycle without a start pulse.
- Stage 2 (accumulate), two states:
  - IDLE: no element of the current vector has been accumulated yet.
  - ACC: at least one element accumulated.
- On p_vld, sign-extend the product to ACC_W+1 bits and form sum = (IDLE ? 0 : acc) + product.
  - If sum > 2^(ACC_W-1)-1, clamp to max and set ovf_sticky.
  - If sum < -2^(ACC_W-1), clamp to min and set ovf_sticky.
  - Later elements continue from the clamped value; there is no wrap-around.
- cnt = (IDLE ? 1 : cnt+1), saturating at all-ones.
- p_vld & !p_last: acc <= sat(sum); state -> ACC.
- p_vld & p_last:
  - o_res <= sat(sum); o_ovf <= ovf_sticky or the current-element overflow; o_cnt <= updated cnt.
  - o_done_pls <= 1; acc, cnt and ovf_sticky cleared; state -> IDLE.
- A single-element vector (first pair has i_last=1) goes IDLE -> IDLE and reports the product.
- A new vector may start in the cycle after the last pair; vectors never mix.
- No p_vld: acc, cnt and state hold.
- Reset values (rst or sw_rst): state IDLE, acc 0, cnt 0, ovf_sticky 0, p_vld 0, o_done_pls 0, o_res 0, o_ovf 0, o_cnt 0.
- rst or sw_rst mid-vector: the partial vector is discarded, no o_done_pls is produced, and the next start pulse begins a fresh vector.

## Timing
- i_start_pls sampled at edge N -> product registered at edge N.
- Accumulated at edge N+1.
- For a last element, o_done_pls is high in the cycle after edge N+1. Latency is 2 clocks from the start pulse of the last pair.
- Throughput: one pair per clock, with no bubbles between vectors.
- o_done_pls is never high for two consecutive cycles unless two consecutive pairs both carry i_last.
- sw_rst sampled high at edge N: state is cleared at edge N, and any start pulse in that cycle is ignored.
- rst asserts asynchronously; deassertion is synchronous to the design.

## Test plan
All values use defaults: Q1.5 inputs, ACC_W=14, results in LSB units of 2^-10.
- Basic vector: pairs (6'b000010, 6'b111101) then (6'b000100, 6'b000101, last) -> one o_done_pls 2 clocks after the last pulse, o_res=14'd14 (-6+20), o_ovf=0, o_cnt=2.
- Single element: (6'b100000, 6'b011111, last) -> o_res=14'h3C20 (-992), o_ovf=0, o_cnt=1.
- Saturation: 9 back-to-back pairs (6'b100000, 6'b100000), last on the 9th -> o_res=14'h1FFF, o_ovf=1, o_cnt=9. A following vector of (6'b000001, 6'b000001, last) -> o_res=1, o_ovf=0.
- Back-to-back vectors: the last pair of vector A at cycle t, the first pair of vector B at t+1 -> A and B results are independent. A bench reference model must match on every o_done_pls over 1000 random vectors of random length, including negative saturation.
- Soft reset mid-vector: 3 pairs, then sw_rst for 1 cycle, then (6'b000010, 6'b000010, last) -> no done pulse for the aborted vector; o_res=4, o_cnt=1.
- Async reset: assert rst between clock edges while p_vld=1 -> all outputs 0 immediately, and no o_done_pls after release.

Source files
------------

// File: rtl/gen_fip_sign_mac.sv
// gen_fip_sign_mac
// Two-stage signed fixed-point multiply-accumulate. Stage 1 registers the
// exact product of each operand pair. Stage 2 adds it into a saturating
// accumulator. The last pair of a vector produces a one-cycle done pulse
// with the saturated dot product, a sticky overflow flag and the element count.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset, clears all state
//   sw_rst       synchronous soft reset, same effect as rst, highest priority
//   i_start_pls  operand pair (and i_last) valid this cycle
//   i_num1       signed Q(IN_INT_W.IN_FRACT_W) operand
//   i_num2       signed Q(IN_INT_W.IN_FRACT_W) operand
//   i_last       pair is the final element of its vector
//   o_done_pls   one-cycle pulse, result outputs updated
//   o_res        saturated dot product, Q(ACC_INT_W.2*IN_FRACT_W)
//   o_ovf        a saturation occurred somewhere in the reported vector
//   o_cnt        element count of the reported vector, saturating
//
// Flow control: there is no back-pressure. A pair is taken in every cycle
// i_start_pls is high. o_done_pls is a pure pulse with no acknowledge, and
// the result outputs hold until the next pulse.
module gen_fip_sign_mac #(
    parameter int IN_INT_W   = 1,
    parameter int IN_FRACT_W = 5,
    parameter int ACC_INT_W  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       sw_rst,
    input  logic                                       i_start_pls,
    input  logic [IN_INT_W+IN_FRACT_W-1:0]             i_num1,
    input  logic [IN_INT_W+IN_FRACT_W-1:0]             i_num2,
    input  logic                                       i_last,
    output logic                                       o_done_pls,
    output logic [ACC_INT_W+2*IN_FRACT_W-1:0]          o_res,
    output logic                                       o_ovf,
    output logic [CNT_W-1:0]                           o_cnt
);

    localparam int IN_W   = IN_INT_W + IN_FRACT_W;
    localparam int PROD_W = 2 * IN_W;
    localparam int ACC_W  = ACC_INT_W + 2 * IN_FRACT_W;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                    state, state_nxt;

    // Stage 1 registers
    logic signed [PROD_W-1:0]  p_prod;
    logic                      p_vld;
    logic                      p_last;

    // Stage 2 registers and next values
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      ovf_sticky, ovf_sticky_nxt;
    logic                      done_nxt;
    logic [ACC_W-1:0]          res_nxt;
    logic                      ovf_out_nxt;
    logic [CNT_W-1:0]          cnt_out_nxt;

    // Datapath
    logic signed [ACC_W:0]     acc_ext;
    logic signed [ACC_W:0]     prod_ext;
    logic signed [ACC_W:0]     sum;
    logic                      elem_ovf;
    logic [ACC_W-1:0]          sum_sat;
    logic [CNT_W-1:0]          cnt_inc;

    // Stage 1: exact product. ACC_W >= PROD_W, so no precision is lost later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_prod <= '0;
            p_vld  <= 1'b0;
            p_last <= 1'b0;
        end else if (sw_rst) begin
            p_prod <= '0;
            p_vld  <= 1'b0;
            p_last <= 1'b0;
        end else begin
            p_vld <= i_start_pls;
            if (i_start_pls) begin
                p_prod <= $signed(i_num1) * $signed(i_num2);
                p_last <= i_last;
            end
        end
    end

    // One guard bit above the accumulator is enough: the sum of two ACC_W
    // values always fits in ACC_W+1 bits. Overflow shows as a mismatch
    // between the guard bit and the accumulator sign bit.
    always_comb begin
        acc_ext  = (state == IDLE) ? '0 : {acc[ACC_W-1], acc};
        prod_ext = {{(ACC_W + 1 - PROD_W){p_prod[PROD_W-1]}}, p_prod};
        sum      = acc_ext + prod_ext;
        elem_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        if (!elem_ovf)
            sum_sat = sum[ACC_W-1:0];
        else if (sum[ACC_W])
            sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
        else
            sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
        if (state == IDLE)
            cnt_inc = CNT_W'(1);
        else if (&cnt)
            cnt_inc = cnt;
        else
            cnt_inc = cnt + CNT_W'(1);
    end

    // Stage 2 next-state and output logic
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        ovf_sticky_nxt = ovf_sticky;
        done_nxt       = 1'b0;
        res_nxt        = o_res;
        ovf_out_nxt    = o_ovf;
        cnt_out_nxt    = o_cnt;
        if (p_vld) begin
            if (!p_last) begin
                acc_nxt        = sum_sat;
                cnt_nxt        = cnt_inc;
                ovf_sticky_nxt = ovf_sticky | elem_ovf;
                state_nxt      = ACC;
            end else begin
                res_nxt        = sum_sat;
                ovf_out_nxt    = ovf_sticky | elem_ovf;
                cnt_out_nxt    = cnt_inc;
                done_nxt       = 1'b1;
                acc_nxt        = '0;
                cnt_nxt        = '0;
                ovf_sticky_nxt = 1'b0;
                state_nxt      = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            o_done_pls <= 1'b0;
            o_res      <= '0;
            o_ovf      <= 1'b0;
            o_cnt      <= '0;
        end else if (sw_rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            o_done_pls <= 1'b0;
            o_res      <= '0;
            o_ovf      <= 1'b0;
            o_cnt      <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            ovf_sticky <= ovf_sticky_nxt;
            o_done_pls <= done_nxt;
            o_res      <= res_nxt;
            o_ovf      <= ovf_out_nxt;
            o_cnt      <= cnt_out_nxt;
        end
    end

endmodule

// File: tb/tb_gen_fip_sign_mac.sv
// Testbench for gen_fip_sign_mac at default parameters (Q1.5 inputs, 14-bit result).
module tb_gen_fip_sign_mac;

    localparam int IN_W  = 6;
    localparam int ACC_W = 14;
    localparam int CNT_W = 8;
    localparam int RES_MAX = 8191;
    localparam int RES_MIN = -8192;
    localparam int EXP_W = ACC_W + 1 + CNT_W;

    logic              clk;
    logic              rst;
    logic              sw_rst;
    logic              i_start_pls;
    logic [IN_W-1:0]   i_num1;
    logic [IN_W-1:0]   i_num2;
    logic              i_last;
    logic              o_done_pls;
    logic [ACC_W-1:0]  o_res;
    logic              o_ovf;
    logic [CNT_W-1:0]  o_cnt;

    gen_fip_sign_mac dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst      (sw_rst),
        .i_start_pls (i_start_pls),
        .i_num1      (i_num1),
        .i_num2      (i_num2),
        .i_last      (i_last),
        .o_done_pls  (o_done_pls),
        .o_res       (o_res),
        .o_ovf       (o_ovf),
        .o_cnt       (o_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];   // {res, ovf, cnt}
    int               due_q[$];   // cycle in which o_done_pls must be seen
    logic [EXP_W-1:0] hold = '0;  // last reported result, must stay on outputs
    int               cur_prods[$];
    bit               swr_hit = 0;

    // Reference: plain integer accumulation with clamping after each element.
    task automatic model_finish_vector(input int due);
        int acc;
        bit ov;
        int n;
        logic [ACC_W-1:0] r;
        logic [CNT_W-1:0] c;
        acc = 0;
        ov  = 0;
        foreach (cur_prods[i]) begin
            acc = acc + cur_prods[i];
            if (acc > RES_MAX) begin acc = RES_MAX; ov = 1; end
            else if (acc < RES_MIN) begin acc = RES_MIN; ov = 1; end
        end
        n = cur_prods.size();
        c = (n > 255) ? 8'd255 : n[7:0];
        r = acc[ACC_W-1:0];
        exp_q.push_back({r, ov, c});
        due_q.push_back(due);
        cur_prods.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic last);
        int pa;
        int pb;
        @(posedge clk);
        #1;
        i_start_pls = 1'b1;
        i_num1      = a;
        i_num2      = b;
        i_last      = last;
        pa = $signed(a);
        pb = $signed(b);
        cur_prods.push_back(pa * pb);
        if (last) model_finish_vector(cyc + 2);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        i_start_pls = 1'b0;
        i_last      = 1'b0;
        i_num1      = '0;
        i_num2      = '0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic soft_reset();
        @(posedge clk);
        #1;
        sw_rst      = 1'b1;
        i_start_pls = 1'b0;
        i_last      = 1'b0;
        cur_prods.delete();
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit found;
        found = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (o_done_pls) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_timeout: got no o_done_pls within %0d cycles, expected one", name, max_cycles);
        end
    endtask

    // ---------------- compare process ----------------
    always @(posedge clk) if (sw_rst && !rst) swr_hit = 1;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst) begin
            if (swr_hit) begin
                exp_q.delete();
                due_q.delete();
                hold    = '0;
                swr_hit = 0;
            end
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale_expect: got nothing, expected done in cycle %0d (now %0d)", due_q[0], cyc);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                n_checks++;
                if (o_done_pls !== 1'b1 || {o_res, o_ovf, o_cnt} !== e) begin
                    n_fail++;
                    $display("FAIL done_result cyc %0d: got done=%0b res=0x%0h ovf=%0b cnt=%0d, expected done=1 res=0x%0h ovf=%0b cnt=%0d",
                             cyc, o_done_pls, o_res, o_ovf, o_cnt, e[EXP_W-1:CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
                end
                hold = e;
            end else begin
                n_checks++;
                if (o_done_pls !== 1'b0 || {o_res, o_ovf, o_cnt} !== hold) begin
                    n_fail++;
                    $display("FAIL idle_hold cyc %0d: got done=%0b res=0x%0h ovf=%0b cnt=%0d, expected done=0 res=0x%0h ovf=%0b cnt=%0d",
                             cyc, o_done_pls, o_res, o_ovf, o_cnt, hold[EXP_W-1:CNT_W+1], hold[CNT_W], hold[CNT_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int len;
        int mode;
        logic [IN_W-1:0] a;
        logic [IN_W-1:0] b;

        rst = 1'b1; sw_rst = 1'b0; i_start_pls = 1'b0;
        i_num1 = '0; i_num2 = '0; i_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", o_done_pls, 0);
        chk("reset_res",  o_res, 0);
        chk("reset_ovf",  o_ovf, 0);
        chk("reset_cnt",  o_cnt, 0);
        rst = 1'b0;
        idle(2);

        // Basic vector: -6 + 20 = 14
        send(6'b000010, 6'b111101, 1'b0);
        send(6'b000100, 6'b000101, 1'b1);
        idle(1);
        wait_done("basic", 6);
        chk("basic_res", o_res, 14);
        chk("basic_ovf", o_ovf, 0);
        chk("basic_cnt", o_cnt, 2);

        // Single element: -32 * 31 = -992
        send(6'b100000, 6'b011111, 1'b1);
        idle(1);
        wait_done("single", 6);
        chk("single_res", o_res, 14'h3C20);
        chk("single_ovf", o_ovf, 0);
        chk("single_cnt", o_cnt, 1);

        // Positive saturation: 9 x 1024 clamps at 8191
        for (int i = 0; i < 9; i++) send(6'b100000, 6'b100000, i == 8);
        idle(1);
        wait_done("sat", 6);
        chk("sat_res", o_res, 14'h1FFF);
        chk("sat_ovf", o_ovf, 1);
        chk("sat_cnt", o_cnt, 9);
        send(6'b000001, 6'b000001, 1'b1);
        idle(1);
        wait_done("after_sat", 6);
        chk("after_sat_res", o_res, 1);
        chk("after_sat_ovf", o_ovf, 0);
        chk("after_sat_cnt", o_cnt, 1);

        // Two single-element vectors back to back: consecutive done pulses
        send(6'b000001, 6'b000011, 1'b1);
        send(6'b111111, 6'b000010, 1'b1);
        idle(4);

        // Soft reset mid-vector
        send(6'b000011, 6'b000011, 1'b0);
        send(6'b000011, 6'b000011, 1'b0);
        send(6'b000011, 6'b000011, 1'b0);
        soft_reset();
        send(6'b000010, 6'b000010, 1'b1);
        idle(1);
        wait_done("swrst", 6);
        chk("swrst_res", o_res, 4);
        chk("swrst_cnt", o_cnt, 1);

        // Element counter saturation
        for (int i = 0; i < 260; i++) send(6'b000000, 6'b000000, i == 259);
        idle(1);
        wait_done("cntsat", 6);
        chk("cntsat_cnt", o_cnt, 255);
        chk("cntsat_res", o_res, 0);

        // Random vectors, including back-to-back and negative saturation
        for (int v = 0; v < 1000; v++) begin
            len  = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0: begin a = IN_W'($urandom_range(0, 63)); b = IN_W'($urandom_range(0, 63)); end
                    1: begin a = 6'b100000; b = ($urandom_range(0, 1) == 1) ? 6'b100000 : 6'b100001; end
                    2: begin a = 6'b100000; b = 6'b011111; end
                    default: begin a = IN_W'($urandom_range(0, 63)); b = IN_W'($urandom_range(0, 3)); end
                endcase
                send(a, b, i == len - 1);
            end
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(4);

        // Asynchronous reset while a last pair sits in stage 1
        send(6'b000010, 6'b000011, 1'b1);
        idle(1);
        wait_done("pre_arst", 6);
        chk("pre_arst_res", o_res, 6);
        send(6'b000101, 6'b000101, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        i_start_pls = 1'b0;
        i_last = 1'b0;
        exp_q.delete();
        due_q.delete();
        cur_prods.delete();
        hold = '0;
        #1;
        chk("arst_done", o_done_pls, 0);
        chk("arst_res",  o_res, 0);
        chk("arst_ovf",  o_ovf, 0);
        chk("arst_cnt",  o_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending results, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
